// File: rtl/aes_dec_pkg.sv
// Shared constants, types and helpers for the AES decryption datapath.
package aes_dec_pkg;

   localparam int NR      = 10;   // number of rounds; key table holds NR+1 entries
   localparam int RW      = 4;    // round-index width; 2**RW must exceed NR
   localparam int STATE_W = 128;  // AES state / round-key width

   typedef logic [RW-1:0]      round_t;
   typedef logic [STATE_W-1:0] state_t;

   // Highest legal round index, typed so comparisons stay width-clean
   localparam round_t LAST_ROUND = round_t'(NR);

   // Rounds 1..NR-1 are followed by InvMixColumns; round NR (initial key add)
   // and round 0 (final plaintext) are not.
   function automatic logic is_mix_round(input round_t r);
      return (r != '0) && (r < LAST_ROUND);
   endfunction

endpackage

// File: rtl/aes_round_key_table.sv
// Expanded round-key table: (NR+1) x 128-bit registers with a loaded bitmap,
// one synchronous write port and one combinational read port.
module aes_round_key_table
   import aes_dec_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   wr_en,
   input  round_t wr_idx,
   input  state_t wr_data,
   input  round_t rd_idx,
   output state_t rd_key,
   output logic   rd_loaded
);

   state_t      key_mem [0:NR];
   logic [NR:0] key_loaded;

   // Key storage and loaded bitmap; out-of-range write indices are dropped.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; the read port below therefore sees the old key when a
   // write and a read of the same index share a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this table is a handful of flops, not a RAM macro, so it is
         // cleared on reset; a reset must genuinely invalidate every key.
         for (int i = 0; i <= NR; i++) begin
            key_mem[i] <= '0;
         end
         key_loaded <= '0;
      end else if (wr_en && (wr_idx <= LAST_ROUND)) begin
         key_mem[wr_idx]    <= wr_data;
         key_loaded[wr_idx] <= 1'b1;
      end
   end

   // Combinational read; indices beyond NR read as an unloaded all-zero key.
   always_comb begin
      // NOTE: defaults first so no path leaves an output unassigned (no latch).
      rd_key    = '0;
      rd_loaded = 1'b0;
      if (rd_idx <= LAST_ROUND) begin
         rd_key    = key_mem[rd_idx];
         rd_loaded = key_loaded[rd_idx];
      end
   end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of the decryption datapath, upstream of
// InvMixColumns. Applies key[in_round] to in_state with a valid/ready
// handshake, latency 1, throughput 1 per cycle.
module inv_add_round_key_stage
   import aes_dec_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               key_wr_en,
   input  logic [RW-1:0]      key_wr_idx,
   input  logic [STATE_W-1:0] key_wr_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   input  logic [RW-1:0]      in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic [RW-1:0]      out_round,
   output logic               out_mix,
   output logic               out_last,
   output logic               out_err,
   output logic               err_sticky
);

   state_t rd_key;
   logic   rd_loaded;
   logic   accept;
   logic   bad_round;

   aes_round_key_table u_key_table (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (key_wr_en),
      .wr_idx    (key_wr_idx),
      .wr_data   (key_wr_data),
      .rd_idx    (in_round),
      .rd_key    (rd_key),
      .rd_loaded (rd_loaded)
   );

   // Output register is free when empty or being drained this cycle.
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign bad_round = (in_round > LAST_ROUND) || !rd_loaded;

   // Output register: capture on accept, otherwise hold or drop valid after transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_state  <= '0;
         out_round  <= '0;
         out_mix    <= 1'b0;
         out_last   <= 1'b0;
         out_err    <= 1'b0;
         err_sticky <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_round <= in_round;
         out_err   <= bad_round;
         if (bad_round) begin
            // Pass the state through untouched so the fault is visible downstream
            out_state  <= in_state;
            out_mix    <= 1'b0;
            out_last   <= 1'b0;
            err_sticky <= 1'b1;
         end else begin
            out_state <= in_state ^ rd_key;
            out_mix   <= is_mix_round(in_round);
            out_last  <= (in_round == '0);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed self-checking bench for inv_add_round_key_stage.
module tb_inv_add_round_key_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_wr_en;
   logic [3:0]   key_wr_idx;
   logic [127:0] key_wr_data;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic [3:0]   in_round;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic [3:0]   out_round;
   logic         out_mix;
   logic         out_last;
   logic         out_err;
   logic         err_sticky;

   int n_cmp  = 0;
   int n_fail = 0;

   // FIPS-197 App. C.1 expanded key, rounds 0..10
   logic [127:0] rk [0:10];
   logic [127:0] s_a;
   logic [127:0] s_b;
   logic [127:0] new_k5;

   inv_add_round_key_stage dut (
      .clk         (clk),
      .rst         (rst),
      .key_wr_en   (key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .in_round    (in_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state),
      .out_round   (out_round),
      .out_mix     (out_mix),
      .out_last    (out_last),
      .out_err     (out_err),
      .err_sticky  (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

      rst = 1'b1; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
      in_valid = 1'b0; in_state = '0; in_round = '0; out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_state", out_state, 0);
      chk("rst_out_round", out_round, 0);
      chk("rst_flags", {out_mix, out_last, out_err}, 0);
      chk("rst_err_sticky", err_sticky, 0);
      chk("rst_in_ready", in_ready, 1);

      // Load the key table serially
      for (int i = 0; i <= 10; i++) begin
         key_wr_en = 1'b1; key_wr_idx = 4'(i); key_wr_data = rk[i];
         step();
      end
      key_wr_en = 1'b0;

      // 1. FIPS-197 C.1 initial key add, round 10
      in_valid = 1'b1; in_round = 4'd10;
      in_state = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      #1;
      chk("t1_pre_valid", out_valid, 0);
      step();
      in_valid = 1'b0;
      chk("t1_valid", out_valid, 1);
      chk("t1_state", out_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
      chk("t1_round", out_round, 10);
      chk("t1_mix", out_mix, 0);
      chk("t1_last", out_last, 0);
      chk("t1_err", out_err, 0);
      step();
      chk("t1_drain", out_valid, 0);

      // 2. Back-to-back rounds 9..0, one result per cycle
      for (int r = 9; r >= 0; r--) begin
         in_valid = 1'b1; in_round = 4'(r);
         in_state = {4{32'hdeadbeef}} ^ {16{8'(r * 17)}};
         s_a = in_state ^ rk[r];
         step();
         chk("t2_valid", out_valid, 1);
         chk("t2_state", out_state, s_a);
         chk("t2_round", out_round, 128'(r));
         chk("t2_mix", out_mix, (r != 0) ? 1 : 0);
         chk("t2_last", out_last, (r == 0) ? 1 : 0);
      end
      in_valid = 1'b0;
      step();
      chk("t2_drain", out_valid, 0);

      // 3. Backpressure: hold 3 cycles, then accept pending input on release
      out_ready = 1'b0;
      in_valid = 1'b1; in_round = 4'd1; in_state = 128'h0123456789abcdef0011223344556677;
      s_a = in_state ^ rk[1];
      step();
      in_round = 4'd2; in_state = 128'hffeeddccbbaa99887766554433221100;
      s_b = in_state ^ rk[2];
      for (int c = 0; c < 3; c++) begin
         chk("t3_in_ready_low", in_ready, 0);
         step();
         chk("t3_hold_valid", out_valid, 1);
         chk("t3_hold_state", out_state, s_a);
         chk("t3_hold_round", out_round, 1);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_in_ready_rel", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("t3_next_valid", out_valid, 1);
      chk("t3_next_state", out_state, s_b);
      chk("t3_next_round", out_round, 2);
      step();
      chk("t3_drain", out_valid, 0);

      // 4. Same-cycle key write and accept on index 5 uses the old key
      new_k5 = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
      key_wr_en = 1'b1; key_wr_idx = 4'd5; key_wr_data = new_k5;
      in_valid = 1'b1; in_round = 4'd5; in_state = 128'h00112233445566778899aabbccddeeff;
      step();
      key_wr_en = 1'b0;
      chk("t4_old_key", out_state, 128'h00112233445566778899aabbccddeeff ^ rk[5]);
      step();
      in_valid = 1'b0;
      chk("t4_new_key", out_state, 128'h00112233445566778899aabbccddeeff ^ new_k5);
      step();

      // 5. Unloaded key and out-of-range round after reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_round = 4'd3; in_state = 128'hcafef00dcafef00dcafef00dcafef00d;
      step();
      chk("t5_err", out_err, 1);
      chk("t5_state", out_state, 128'hcafef00dcafef00dcafef00dcafef00d);
      chk("t5_sticky", err_sticky, 1);
      chk("t5_flags", {out_mix, out_last}, 0);
      in_round = 4'd12; in_state = 128'h1;
      step();
      in_valid = 1'b0;
      chk("t5b_err", out_err, 1);
      chk("t5b_state", out_state, 128'h1);
      chk("t5b_round", out_round, 12);
      chk("t5b_sticky", err_sticky, 1);
      step();

      // 6. Reset while a result is held discards it and clears the key table
      rst = 1'b1;
      step();
      rst = 1'b0;
      key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = rk[0];
      step();
      key_wr_en = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1; in_round = 4'd0; in_state = 128'h55;
      step();
      in_valid = 1'b0;
      chk("t6_held_valid", out_valid, 1);
      chk("t6_held_last", out_last, 1);
      chk("t6_held_err", out_err, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_sticky", err_sticky, 0);
      out_ready = 1'b1;
      in_valid = 1'b1; in_round = 4'd0; in_state = 128'h77;
      step();
      in_valid = 1'b0;
      chk("t6_err", out_err, 1);
      chk("t6_state", out_state, 128'h77);
      chk("t6_last", out_last, 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
